mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the single 16-bit off-chip SRAM between instruction fetch (PC/IF stage) and data access (MEM stage). It sequences the multi-cycle SRAM read and write strobes and raises stall requests toward the stall controller until each access completes. Within one cycle, MEM-stage accesses win over fetch.

## Interface
Parameters:
- RD_WAIT, default 1: extra cycles `ram_oe_n` is held low before read data is sampled (1..7).
- WR_WAIT, default 1: cycles `ram_we_n` is held low per write (1..7).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- if_ce  in  1  fetch request; this is the PC chip enable.
- if_addr  in  16  fetch address; this is the PC.
- if_inst  out  16  fetched instruction; valid in the cycle `if_done`=1.
- if_done  out  1  one-cycle pulse when the fetch completes.
- mem_ce  in  1  data access request.
- mem_we  in  1  1 = write, 0 = read.
- mem_addr  in  16  data address.
- mem_wdata  in  16  write data.
- mem_rdata  out  16  read data; valid in the cycle `mem_done`=1.
- mem_done  out  1  one-cycle pulse when the data access completes.
- stallreq_if  out  1  fetch stall request to the stall controller.
- stallreq_mem  out  1  MEM stall request to the stall controller.
- ram_addr  out  16  SRAM address.
- ram_dout  out  16  SRAM write data.
- ram_din  in  16  SRAM read data.
- ram_en_n, ram_oe_n, ram_we_n  out  1 each  active-low SRAM strobes.

## Operation
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD. A 3-bit wait counter `cnt` sequences the waits.
- IDLE:
  - `mem_ce`=1: latch `mem_addr`/`mem_wdata`/`mem_we`, then go to WR_SETUP (write) or RD (read, owner=MEM).
  - Else if `if_ce`=1 (and no buffer hit when configured): latch `if_addr`, go to RD (owner=IF).
  - Else stay in IDLE.
- RD:
  - `ram_en_n`=0, `ram_oe_n`=0, `ram_addr` = latched address. `cnt` counts 0..RD_WAIT.
  - When `cnt`=RD_WAIT: register `ram_din` into the owner's data output, pulse the owner's done, return to IDLE.
- WR_SETUP: 1 cycle; `ram_en_n`=0, address and data driven, `ram_we_n`=1.
- WR_PULSE: WR_WAIT cycles with `ram_we_n`=0.
- WR_HOLD: 1 cycle with `ram_we_n`=1 and address/data still held. Then pulse `mem_done` and return to IDLE.
- Stall requests (combinational):
  - `stallreq_mem` = `mem_ce` & ~`mem_done`.
  - `stallreq_if` = `if_ce` & ~`if_done`.
  - An IF request waiting behind a MEM access therefore stays stalled.
- Withdrawn requests:
  - A read whose request drops before completion is abandoned; return to IDLE next cycle with no done pulse.
  - A write is always completed once WR_SETUP is entered.
- Each completion is followed by at least one cycle in IDLE, which is where arbitration happens.

## Timing
- Reset values: all strobes 1; `ram_addr`, `ram_dout`, `if_inst`, `mem_rdata` = 0; `if_done`, `mem_done` = 0; state IDLE; `cnt` = 0.
- Reset asserted mid-access aborts the access immediately, including a write in WR_PULSE.
- Read latency from request seen in IDLE to done pulse: RD_WAIT+2 cycles (default 3).
- Write latency from request seen in IDLE to `mem_done`: WR_WAIT+3 cycles (default 4).
- Done pulses and data outputs are registered. Data outputs hold their value until the next completion.
- Simultaneous `if_ce` and `mem_ce` in IDLE: MEM is served first. IF is served from the IDLE cycle after `mem_done`.

## Configuration
- `ARB_IBUF_EN` defined:
  - Adds a one-entry fetch buffer holding {valid, addr, inst}, filled on every IF completion.
  - In IDLE, `if_ce`=1 with `if_addr` matching a valid entry: no SRAM access; `if_done` pulses next cycle with the buffered instruction.
  - A MEM write whose address matches clears `valid` on entering WR_SETUP.
- `ARB_IBUF_EN` undefined: no buffer; every fetch accesses the SRAM.

## Structure
- Shared defines header gets:
  - state encodings `ArbIdle`, `ArbRd`, `ArbWrSetup`, `ArbWrPulse`, `ArbWrHold`;
  - owner constants `OwnerIf`, `OwnerMem`.
- Existing `RstEnable`, `ChipEnable`, `Enable`/`Disable` are reused.
- Sub-module `arb_ibuf` contains the fetch buffer. It is instantiated only under `ARB_IBUF_EN`.

## Test plan
- Reset: assert `rst` mid-WR_PULSE → `ram_we_n`=1 asynchronously, state IDLE, all outputs 0.
- IF read: `if_ce`=1, `if_addr`=0x0010, SRAM[0x0010]=0x4A21, defaults → `if_done` 3 cycles later, `if_inst`=0x4A21, `stallreq_if` high for 3 cycles.
- MEM write: `mem_we`=1, addr 0x8000, data 0xBEEF → `ram_we_n` low for exactly 1 cycle with addr/data stable on both sides; `mem_done` after 4 cycles.
- Conflict: `if_ce` and a MEM read of 0x8000 raised in the same cycle → MEM served first, `mem_rdata`=0xBEEF; IF done 4 cycles after `mem_done`; `stallreq_if` high throughout.
- Withdraw: drop `if_ce` during RD → no `if_done`, IDLE next cycle.
- `ARB_IBUF_EN`: fetch 0x0010 twice → second fetch makes no SRAM access, `if_done` after 1 cycle. Then write 0x0010 and fetch again → full SRAM read.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the SRAM arbiter between instruction fetch and the MEM stage.
package mem_arbiter_pkg;

    localparam logic RstEnable  = 1'b1;
    localparam logic ChipEnable = 1'b1;
    localparam logic Enable     = 1'b1;
    localparam logic Disable    = 1'b0;

    localparam logic [2:0] ArbIdle    = 3'd0;
    localparam logic [2:0] ArbRd      = 3'd1;
    localparam logic [2:0] ArbWrSetup = 3'd2;
    localparam logic [2:0] ArbWrPulse = 3'd3;
    localparam logic [2:0] ArbWrHold  = 3'd4;

    localparam logic OwnerIf  = 1'b0;
    localparam logic OwnerMem = 1'b1;

    typedef struct packed {
        logic        valid;
        logic [15:0] addr;
        logic [15:0] inst;
    } ibuf_entry_t;

endpackage

// File: rtl/mem_arbiter_ibuf.sv
// One-entry fetch buffer: remembers the last fetched {addr, inst} so a repeated fetch skips the SRAM.
module arb_ibuf
    import mem_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] lookup_addr,
    output logic        hit,
    output logic [15:0] hit_inst,
    input  logic        fill,
    input  logic [15:0] fill_addr,
    input  logic [15:0] fill_inst,
    input  logic        inval,
    input  logic [15:0] inval_addr
);

    ibuf_entry_t entry_r;

    // Fill on every fetch completion; a write to the buffered address drops the entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            entry_r <= '0;
        end else if (fill) begin
            entry_r <= '{valid: 1'b1, addr: fill_addr, inst: fill_inst};
        end else if (inval && (entry_r.addr == inval_addr)) begin
            entry_r.valid <= 1'b0;
        end else begin
            entry_r <= entry_r;
        end
    end

    assign hit      = entry_r.valid && (entry_r.addr == lookup_addr);
    assign hit_inst = entry_r.inst;

endmodule

// File: rtl/mem_arbiter.sv
// SRAM arbiter: MEM accesses beat fetches, multi-cycle read/write strobing, stall requests.
// Optional one-entry fetch buffer enabled by defining ARB_IBUF_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_ce,
    input  logic [15:0] if_addr,
    output logic [15:0] if_inst,
    output logic        if_done,
    input  logic        mem_ce,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_done,
    output logic        stallreq_if,
    output logic        stallreq_mem,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_dout,
    input  logic [15:0] ram_din,
    output logic        ram_en_n,
    output logic        ram_oe_n,
    output logic        ram_we_n
);

    localparam logic [2:0] RdLast = 3'(RD_WAIT);
    localparam logic [2:0] WrLast = 3'(WR_WAIT - 1);

    logic [2:0]  state_r;
    logic [2:0]  state_next_s;
    logic [2:0]  cnt_r;
    logic        owner_r;
    logic [15:0] ram_addr_r;
    logic [15:0] ram_dout_r;
    logic [15:0] if_inst_r;
    logic [15:0] mem_rdata_r;
    logic        if_done_r;
    logic        mem_done_r;
    logic        ram_en_n_r;
    logic        ram_oe_n_r;
    logic        ram_we_n_r;
    logic        req_live_s;
    logic        idle_arb_s;
    logic        rd_finish_s;
    logic        ibuf_hit_s;
    logic [15:0] ibuf_inst_s;

    // The cycle carrying a done pulse is a dead IDLE cycle so a still-raised request is not served twice
    assign idle_arb_s  = !(if_done_r || mem_done_r);
    assign req_live_s  = (owner_r == OwnerMem) ? mem_ce : if_ce;
    assign rd_finish_s = req_live_s && (cnt_r == RdLast);

`ifdef ARB_IBUF_EN
    logic ibuf_fill_s;
    logic ibuf_inval_s;

    assign ibuf_fill_s  = (state_r == ArbRd) && (owner_r == OwnerIf) && rd_finish_s;
    assign ibuf_inval_s = (state_r == ArbIdle) && (state_next_s == ArbWrSetup);

    arb_ibuf u_ibuf (
        .clk         (clk),
        .rst         (rst),
        .lookup_addr (if_addr),
        .hit         (ibuf_hit_s),
        .hit_inst    (ibuf_inst_s),
        .fill        (ibuf_fill_s),
        .fill_addr   (ram_addr_r),
        .fill_inst   (ram_din),
        .inval       (ibuf_inval_s),
        .inval_addr  (mem_addr)
    );
`else
    assign ibuf_hit_s  = 1'b0;
    assign ibuf_inst_s = 16'h0000;
`endif

    // Next-state selection; a read whose requester withdraws is abandoned, a write always runs out
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ArbIdle: begin
                if (!idle_arb_s) begin
                    state_next_s = ArbIdle;
                end else if (mem_ce == ChipEnable) begin
                    state_next_s = mem_we ? ArbWrSetup : ArbRd;
                end else if ((if_ce == ChipEnable) && !ibuf_hit_s) begin
                    state_next_s = ArbRd;
                end else begin
                    state_next_s = ArbIdle;
                end
            end
            ArbRd: begin
                if (!req_live_s || (cnt_r == RdLast)) begin
                    state_next_s = ArbIdle;
                end else begin
                    state_next_s = ArbRd;
                end
            end
            ArbWrSetup: state_next_s = ArbWrPulse;
            ArbWrPulse: begin
                if (cnt_r == WrLast) begin
                    state_next_s = ArbWrHold;
                end else begin
                    state_next_s = ArbWrPulse;
                end
            end
            ArbWrHold: state_next_s = ArbIdle;
            default:   state_next_s = ArbIdle;
        endcase
    end

    // State, strobes decoded from the next state, latched request and registered results
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state_r     <= ArbIdle;
            cnt_r       <= 3'd0;
            owner_r     <= OwnerIf;
            ram_addr_r  <= 16'h0000;
            ram_dout_r  <= 16'h0000;
            if_inst_r   <= 16'h0000;
            mem_rdata_r <= 16'h0000;
            if_done_r   <= Disable;
            mem_done_r  <= Disable;
            ram_en_n_r  <= 1'b1;
            ram_oe_n_r  <= 1'b1;
            ram_we_n_r  <= 1'b1;
        end else begin
            state_r    <= state_next_s;
            ram_en_n_r <= (state_next_s == ArbIdle);
            ram_oe_n_r <= (state_next_s != ArbRd);
            ram_we_n_r <= (state_next_s != ArbWrPulse);
            if ((state_next_s == state_r) && (state_r != ArbIdle)) begin
                cnt_r <= cnt_r + 3'd1;
            end else begin
                cnt_r <= 3'd0;
            end
            if_done_r  <= Disable;
            mem_done_r <= Disable;
            case (state_r)
                ArbIdle: begin
                    if (idle_arb_s && (mem_ce == ChipEnable)) begin
                        ram_addr_r <= mem_addr;
                        ram_dout_r <= mem_wdata;
                        owner_r    <= OwnerMem;
                    end else if (idle_arb_s && (if_ce == ChipEnable)) begin
                        if (ibuf_hit_s) begin
                            if_inst_r <= ibuf_inst_s;
                            if_done_r <= Enable;
                        end else begin
                            ram_addr_r <= if_addr;
                            owner_r    <= OwnerIf;
                        end
                    end
                end
                ArbRd: begin
                    if (rd_finish_s && (owner_r == OwnerMem)) begin
                        mem_rdata_r <= ram_din;
                        mem_done_r  <= Enable;
                    end else if (rd_finish_s) begin
                        if_inst_r <= ram_din;
                        if_done_r <= Enable;
                    end
                end
                ArbWrHold: mem_done_r <= Enable;
                default: ;
            endcase
        end
    end

    assign stallreq_mem = mem_ce & ~mem_done_r;
    assign stallreq_if  = if_ce & ~if_done_r;
    assign if_inst      = if_inst_r;
    assign if_done      = if_done_r;
    assign mem_rdata    = mem_rdata_r;
    assign mem_done     = mem_done_r;
    assign ram_addr     = ram_addr_r;
    assign ram_dout     = ram_dout_r;
    assign ram_en_n     = ram_en_n_r;
    assign ram_oe_n     = ram_oe_n_r;
    assign ram_we_n     = ram_we_n_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural SRAM and per-requester expectation queues.
module tb_mem_arbiter;

`ifdef ARB_IBUF_EN
    localparam int HitLat = 1;
    localparam int HitRd  = 0;
`else
    localparam int HitLat = 3;
    localparam int HitRd  = 2;
`endif

    typedef struct {
        logic [15:0] data;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_ce = 1'b0;
    logic [15:0] if_addr = 16'h0000;
    logic [15:0] if_inst;
    logic        if_done;
    logic        mem_ce = 1'b0;
    logic        mem_we = 1'b0;
    logic [15:0] mem_addr = 16'h0000;
    logic [15:0] mem_wdata = 16'h0000;
    logic [15:0] mem_rdata;
    logic        mem_done;
    logic        stallreq_if;
    logic        stallreq_mem;
    logic [15:0] ram_addr;
    logic [15:0] ram_dout;
    logic [15:0] ram_din;
    logic        ram_en_n;
    logic        ram_oe_n;
    logic        ram_we_n;

    logic [15:0] sram [0:65535];
    bit          loaded = 1'b0;
    int          cyc = 0;
    int          rd_cycles = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] last_mem_rdata = 16'h0000;
    exp_t        if_q[$];
    exp_t        mem_q[$];

    mem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .if_ce        (if_ce),
        .if_addr      (if_addr),
        .if_inst      (if_inst),
        .if_done      (if_done),
        .mem_ce       (mem_ce),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_done     (mem_done),
        .stallreq_if  (stallreq_if),
        .stallreq_mem (stallreq_mem),
        .ram_addr     (ram_addr),
        .ram_dout     (ram_dout),
        .ram_din      (ram_din),
        .ram_en_n     (ram_en_n),
        .ram_oe_n     (ram_oe_n),
        .ram_we_n     (ram_we_n)
    );

    always #5 clk = ~clk;

    // SRAM model, cycle counter and count of SRAM read cycles
    always @(posedge clk) begin
        if (!loaded) begin
            sram[16'h0010] = 16'h4A21;
            sram[16'h0020] = 16'h1357;
            sram[16'h0030] = 16'h2468;
            sram[16'h1234] = 16'h0000;
            sram[16'h8000] = 16'h0000;
            loaded = 1'b1;
        end
        if (!ram_en_n && !ram_oe_n) rd_cycles++;
        if (!ram_en_n && !ram_we_n) sram[ram_addr] = ram_dout;
        cyc++;
    end

    assign ram_din = (!ram_en_n && !ram_oe_n) ? sram[ram_addr] : 16'h0000;

    task automatic fetch(input logic [15:0] addr, output logic [15:0] data, output int lat);
        int c0;
        if_ce = 1'b1;
        if_addr = addr;
        c0 = cyc;
        lat = -1;
        data = 16'h0000;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (if_done) begin
                data = if_inst;
                lat = cyc - c0;
                break;
            end
        end
        if_ce = 1'b0;
        @(negedge clk);
    endtask

    task automatic mem_access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                              output logic [15:0] data, output int lat);
        int c0;
        mem_ce = 1'b1;
        mem_we = we;
        mem_addr = addr;
        mem_wdata = wdata;
        c0 = cyc;
        lat = -1;
        data = 16'h0000;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (mem_done) begin
                data = mem_rdata;
                lat = cyc - c0;
                break;
            end
        end
        mem_ce = 1'b0;
        mem_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [67:0] obs;
        logic [67:0] req;
        bit          seen;
        req = {1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
        repeat (3) @(negedge clk);
        obs = {ram_en_n, ram_oe_n, ram_we_n, ram_addr, ram_dout, if_inst, mem_rdata, if_done, mem_done};
        n_cmp++;
        if (obs !== req) begin
            n_bad++;
            $display("FAIL reset_values: got %h want %h", obs, req);
        end
        rst = 1'b0;
        @(negedge clk);
        mem_ce = 1'b1;
        mem_we = 1'b1;
        mem_addr = 16'h1234;
        mem_wdata = 16'h5555;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (!ram_we_n) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL reset_reach_wr_pulse: ram_we_n never went low");
        end
        #2 rst = 1'b1;
        #1;
        obs = {ram_en_n, ram_oe_n, ram_we_n, ram_addr, ram_dout, if_inst, mem_rdata, if_done, mem_done};
        n_cmp++;
        if (obs !== req) begin
            n_bad++;
            $display("FAIL reset_mid_write: got %h want %h", obs, req);
        end
        @(negedge clk);
        mem_ce = 1'b0;
        mem_we = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({ram_en_n, mem_done} !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_idle_after: en_n/mem_done got %b want 10", {ram_en_n, mem_done});
        end
    endtask

    task automatic test_if_read();
        exp_t e;
        int   c0;
        int   stalls;
        bit   seen;
        if_q.push_back('{data: 16'h4A21, lat: 3});
        if_ce = 1'b1;
        if_addr = 16'h0010;
        c0 = cyc;
        #1;
        stalls = stallreq_if ? 1 : 0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (stallreq_if) stalls++;
            if (if_done) begin
                seen = 1'b1;
                e = if_q.pop_front();
                n_cmp++;
                if ((if_inst !== e.data) || ((cyc - c0) != e.lat)) begin
                    n_bad++;
                    $display("FAIL if_read: got %h after %0d want %h after %0d", if_inst, cyc - c0, e.data, e.lat);
                end
                break;
            end
        end
        if_ce = 1'b0;
        n_cmp++;
        if (!seen || (stalls != 3)) begin
            n_bad++;
            $display("FAIL if_read_stall: done_seen %0d stall cycles %0d want 3", seen, stalls);
        end
        @(negedge clk);
    endtask

    task automatic test_mem_write();
        exp_t e;
        int   c0;
        int   en_cnt;
        int   we_cnt;
        bit   seen;
        mem_q.push_back('{data: last_mem_rdata, lat: 4});
        mem_ce = 1'b1;
        mem_we = 1'b1;
        mem_addr = 16'h8000;
        mem_wdata = 16'hBEEF;
        c0 = cyc;
        en_cnt = 0;
        we_cnt = 0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (!ram_en_n) begin
                en_cnt++;
                n_cmp++;
                if ((ram_addr !== 16'h8000) || (ram_dout !== 16'hBEEF)) begin
                    n_bad++;
                    $display("FAIL wr_addr_data: got %h/%h want 8000/beef", ram_addr, ram_dout);
                end
            end
            if (!ram_we_n) we_cnt++;
            if (mem_done) begin
                seen = 1'b1;
                e = mem_q.pop_front();
                n_cmp++;
                if ((mem_rdata !== e.data) || ((cyc - c0) != e.lat)) begin
                    n_bad++;
                    $display("FAIL mem_write_done: rdata %h after %0d want %h after %0d", mem_rdata, cyc - c0, e.data, e.lat);
                end
                break;
            end
        end
        mem_ce = 1'b0;
        mem_we = 1'b0;
        n_cmp++;
        if (!seen || (we_cnt != 1) || (en_cnt != 3)) begin
            n_bad++;
            $display("FAIL wr_strobes: done %0d we_n low %0d want 1, en_n low %0d want 3", seen, we_cnt, en_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_conflict();
        exp_t e;
        int   c0;
        int   mem_at;
        bit   seen;
        mem_q.push_back('{data: 16'hBEEF, lat: 3});
        if_q.push_back('{data: 16'h1357, lat: 7});
        if_ce = 1'b1;
        if_addr = 16'h0020;
        mem_ce = 1'b1;
        mem_we = 1'b0;
        mem_addr = 16'h8000;
        c0 = cyc;
        mem_at = -1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (if_done) begin
                seen = 1'b1;
                e = if_q.pop_front();
                n_cmp++;
                if ((if_inst !== e.data) || ((cyc - c0) != e.lat) || ((cyc - mem_at) != 4)) begin
                    n_bad++;
                    $display("FAIL conflict_if: got %h at %0d (mem at %0d) want %h at %0d", if_inst, cyc - c0, mem_at - c0, e.data, e.lat);
                end
                break;
            end
            n_cmp++;
            if (stallreq_if !== 1'b1) begin
                n_bad++;
                $display("FAIL conflict_stall_if: got %b want 1 at cycle %0d", stallreq_if, cyc - c0);
            end
            if (mem_done) begin
                mem_at = cyc;
                e = mem_q.pop_front();
                last_mem_rdata = e.data;
                n_cmp++;
                if ((mem_rdata !== e.data) || ((cyc - c0) != e.lat)) begin
                    n_bad++;
                    $display("FAIL conflict_mem: got %h at %0d want %h at %0d", mem_rdata, cyc - c0, e.data, e.lat);
                end
                mem_ce = 1'b0;
            end
        end
        if_ce = 1'b0;
        mem_ce = 1'b0;
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL conflict_timeout: if_done not seen");
        end
        @(negedge clk);
    endtask

    task automatic test_withdraw();
        int dones;
        if_ce = 1'b1;
        if_addr = 16'h0010;
        @(negedge clk);
        if_ce = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({ram_en_n, ram_oe_n} !== 2'b11) begin
            n_bad++;
            $display("FAIL withdraw_idle: en_n/oe_n got %b want 11", {ram_en_n, ram_oe_n});
        end
        dones = 0;
        for (int k = 0; k < 6; k++) begin
            if (if_done) dones++;
            @(negedge clk);
        end
        n_cmp++;
        if ((dones != 0) || (if_inst !== 16'h1357)) begin
            n_bad++;
            $display("FAIL withdraw_no_done: pulses %0d inst %h want 0 / 1357", dones, if_inst);
        end
    endtask

    task automatic test_ibuf();
        exp_t        e;
        logic [15:0] d;
        int          lat;
        int          r0;
        if_q.push_back('{data: 16'h2468, lat: 3});
        fetch(16'h0030, d, lat);
        e = if_q.pop_front();
        n_cmp++;
        if ((d !== e.data) || (lat != e.lat)) begin
            n_bad++;
            $display("FAIL ibuf_first: got %h after %0d want %h after %0d", d, lat, e.data, e.lat);
        end
        r0 = rd_cycles;
        if_q.push_back('{data: 16'h2468, lat: HitLat});
        fetch(16'h0030, d, lat);
        e = if_q.pop_front();
        n_cmp++;
        if ((d !== e.data) || (lat != e.lat) || ((rd_cycles - r0) != HitRd)) begin
            n_bad++;
            $display("FAIL ibuf_repeat: got %h after %0d sram rd %0d want %h after %0d rd %0d",
                     d, lat, rd_cycles - r0, e.data, e.lat, HitRd);
        end
        mem_q.push_back('{data: last_mem_rdata, lat: 4});
        mem_access(1'b1, 16'h0030, 16'h9ABC, d, lat);
        e = mem_q.pop_front();
        n_cmp++;
        if ((d !== e.data) || (lat != e.lat)) begin
            n_bad++;
            $display("FAIL ibuf_write: got %h after %0d want %h after %0d", d, lat, e.data, e.lat);
        end
        r0 = rd_cycles;
        if_q.push_back('{data: 16'h9ABC, lat: 3});
        fetch(16'h0030, d, lat);
        e = if_q.pop_front();
        n_cmp++;
        if ((d !== e.data) || (lat != e.lat) || ((rd_cycles - r0) != 2)) begin
            n_bad++;
            $display("FAIL ibuf_after_write: got %h after %0d sram rd %0d want %h after %0d rd 2",
                     d, lat, rd_cycles - r0, e.data, e.lat);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   c0;
        int   got;
        got = 0;
        if_q.push_back('{data: 16'h4A21, lat: 3});
        if_ce = 1'b1;
        if_addr = 16'h0010;
        c0 = cyc;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (if_done) begin
                e = if_q.pop_front();
                n_cmp++;
                if ((if_inst !== e.data) || ((cyc - c0) != e.lat)) begin
                    n_bad++;
                    $display("FAIL b2b_fetch%0d: got %h after %0d want %h after %0d", got, if_inst, cyc - c0, e.data, e.lat);
                end
                got++;
                if (got == 2) break;
                if_q.push_back('{data: 16'h1357, lat: 4});
                if_addr = 16'h0020;
                c0 = cyc;
            end
        end
        if_ce = 1'b0;
        n_cmp++;
        if (got != 2) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d completions want 2", got);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_mem_write();
        test_conflict();
        test_withdraw();
        test_ibuf();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
